// File: rtl/image_pkg.sv
// Shared definitions for the image frame sequencer: FSM state encoding, op codes and default geometry.
package image_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HBLANK = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [1:0] OP_BRIGHT_ADD = 2'd0;
    localparam logic [1:0] OP_BRIGHT_SUB = 2'd1;
    localparam logic [1:0] OP_INVERT     = 2'd2;
    localparam logic [1:0] OP_THRESH     = 2'd3;

    localparam int DEF_WIDTH      = 768;
    localparam int DEF_HEIGHT     = 512;
    localparam int DEF_ROW_W      = 9;
    localparam int DEF_COL_W      = 10;
    localparam int DEF_ADDR_W     = 19;
    localparam int DEF_HBLANK_CYC = 4;

endpackage

// File: rtl/image_addr_gen.sv
// Raster-order row/col/pixel-address counters, two pixels per advance, with end-of-line/frame flags.
module image_addr_gen
    import image_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int ROW_W  = DEF_ROW_W,
    parameter int COL_W  = DEF_COL_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              clear,
    input  logic              advance,
    output logic [ROW_W-1:0]  row,
    output logic [COL_W-1:0]  col,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              at_eol,
    output logic              at_eof
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 2);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);

    assign at_eol = (col == LAST_COL);
    assign at_eof = at_eol && (row == LAST_ROW);

    // The eof beat does not advance: counters keep their final values until the next clear.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            row      <= '0;
            col      <= '0;
            pix_addr <= '0;
        end else if (clear) begin
            row      <= '0;
            col      <= '0;
            pix_addr <= '0;
        end else if (advance && !at_eof) begin
            pix_addr <= pix_addr + ADDR_W'(2);
            if (at_eol) begin
                col <= '0;
                row <= row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(2);
            end
        end
    end

endmodule

// File: rtl/image_frame_sequencer.sv
// Frame-level scheduler walking a frame two pixels per beat over valid/ready.
// Optional horizontal blanking between rows is built when HBLANK_EN is defined.
//
// state  | meaning
// IDLE   | waiting for start; outputs quiet
// RUN    | issuing beats, out_valid=1
// HBLANK | HBLANK_CYC idle cycles after a non-final row (HBLANK_EN only)
// DONE   | one-cycle done pulse, frame counter increments
module image_frame_sequencer
    import image_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int HEIGHT     = DEF_HEIGHT,
    parameter int ROW_W      = DEF_ROW_W,
    parameter int COL_W      = DEF_COL_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int HBLANK_CYC = DEF_HBLANK_CYC
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              start,
    input  logic [1:0]        op_sel,
    input  logic              abort,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [ROW_W-1:0]  row,
    output logic [COL_W-1:0]  col,
    output logic [1:0]        op_cur,
    output logic              sof,
    output logic              eol,
    output logic              eof,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [15:0]       frame_cnt
);

    if ((WIDTH % 2) != 0 || WIDTH < 4 || HEIGHT < 2 || HBLANK_CYC < 1) begin : g_bad_params
        $error("image_frame_sequencer: illegal geometry or blanking parameters");
    end

    state_t state, state_nxt;
    logic   clear, advance, at_eol, at_eof;

    image_addr_gen #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ROW_W  (ROW_W),
        .COL_W  (COL_W),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .clear    (clear),
        .advance  (advance),
        .row      (row),
        .col      (col),
        .pix_addr (pix_addr),
        .at_eol   (at_eol),
        .at_eof   (at_eof)
    );

`ifdef HBLANK_EN
    localparam int BLANK_W = $clog2(HBLANK_CYC + 1);
    logic [BLANK_W-1:0] blank_cnt;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            blank_cnt <= '0;
        else if (state == ST_RUN)
            blank_cnt <= BLANK_W'(HBLANK_CYC - 1);
        else if (state == ST_HBLANK && blank_cnt != '0)
            blank_cnt <= blank_cnt - BLANK_W'(1);
    end
`endif

    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        advance   = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    clear     = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                out_valid = 1'b1;
                // abort wins over a same-cycle accept
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (out_ready) begin
                    advance = 1'b1;
                    if (at_eof)
                        state_nxt = ST_DONE;
`ifdef HBLANK_EN
                    else if (at_eol)
                        state_nxt = ST_HBLANK;
`endif
                end
            end
`ifdef HBLANK_EN
            ST_HBLANK: begin
                if (abort)
                    state_nxt = ST_IDLE;
                else if (blank_cnt == '0)
                    state_nxt = ST_RUN;
            end
`endif
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            op_cur    <= '0;
            frame_cnt <= '0;
            aborted   <= 1'b0;
        end else begin
            state   <= state_nxt;
            aborted <= abort && (state == ST_RUN || state == ST_HBLANK);
            if (state == ST_IDLE && start)
                op_cur <= op_sel;
            if (state == ST_DONE)
                frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);
    assign sof  = out_valid && (row == '0) && (col == '0);
    assign eol  = out_valid && at_eol;
    assign eof  = eol && at_eof;

endmodule

// File: tb/tb_image_frame_sequencer.sv
// Directed self-checking bench for image_frame_sequencer on an 8x4 frame (16 beats).
module tb_image_frame_sequencer;

    localparam int WIDTH      = 8;
    localparam int HEIGHT     = 4;
    localparam int ROW_W      = 2;
    localparam int COL_W      = 3;
    localparam int ADDR_W     = 5;
    localparam int HBLANK_CYC = 2;

    logic              HCLK = 1'b0;
    logic              HRESETn = 1'b0;
    logic              start = 1'b0;
    logic [1:0]        op_sel = 2'd0;
    logic              abort = 1'b0;
    logic              out_ready = 1'b0;
    logic              out_valid;
    logic [ADDR_W-1:0] pix_addr;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [1:0]        op_cur;
    logic              sof, eol, eof, busy, done, aborted;
    logic [15:0]       frame_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    image_frame_sequencer #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .ROW_W(ROW_W), .COL_W(COL_W),
        .ADDR_W(ADDR_W), .HBLANK_CYC(HBLANK_CYC)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .op_sel(op_sel),
        .abort(abort), .out_ready(out_ready), .out_valid(out_valid),
        .pix_addr(pix_addr), .row(row), .col(col), .op_cur(op_cur),
        .sof(sof), .eol(eol), .eof(eof), .busy(busy), .done(done),
        .aborted(aborted), .frame_cnt(frame_cnt)
    );

    always #5 HCLK = ~HCLK;

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    // Counts accepted beats and cycles until done is seen; no checking here.
    task automatic run_to_done(output int beats, output int cycles, output bit timeout);
        beats = 0;
        cycles = 0;
        timeout = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (out_valid && out_ready) beats++;
            step();
            cycles++;
            if (done) begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        repeat (3) step();
        n_tests++;
        if ({out_valid, pix_addr, row, col, op_cur, sof, eol, eof, busy, done, aborted, frame_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%0b addr=%0d row=%0d col=%0d op=%0d busy=%0b cnt=%0d, want all 0",
                     out_valid, pix_addr, row, col, op_cur, busy, frame_cnt);
        end
        HRESETn = 1'b1;
        step();
    endtask

    task automatic test_full_frame();
        logic [ADDR_W+ROW_W+COL_W+3:0] got, exp;
        start = 1'b1; op_sel = 2'd2; out_ready = 1'b1;
        step();
        start = 1'b0;
        for (int b = 1; b <= 16; b++) begin
            exp = {1'b1, ADDR_W'(2*(b-1)), ROW_W'((b-1)/4), COL_W'(2*((b-1)%4)),
                   (b == 1), (b % 4 == 0), (b == 16)};
            got = {out_valid, pix_addr, row, col, sof, eol, eof};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL beat_%0d: got valid/addr/row/col/sof/eol/eof=%b, want %b", b, got, exp);
            end
            step();
        end
        n_tests++;
        if ({done, busy, out_valid, pix_addr} !== {3'b110, ADDR_W'(30)}) begin
            n_fail++;
            $display("FAIL done_pulse: got done=%0b busy=%0b valid=%0b addr=%0d, want 1 1 0 30",
                     done, busy, out_valid, pix_addr);
        end
        step();
        n_tests++;
        if ({done, busy, frame_cnt, op_cur} !== {2'b00, 16'd1, 2'd2}) begin
            n_fail++;
            $display("FAIL after_frame1: got done=%0b busy=%0b cnt=%0d op=%0d, want 0 0 1 2",
                     done, busy, frame_cnt, op_cur);
        end
    endtask

    task automatic test_backpressure();
        int beats, cycles;
        bit to;
        start = 1'b1; op_sel = 2'd0; out_ready = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if ({out_valid, pix_addr, row, col} !== {1'b1, ADDR_W'(10), ROW_W'(1), COL_W'(2)}) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: got valid=%0b addr=%0d row=%0d col=%0d, want 1 10 1 2",
                         i, out_valid, pix_addr, row, col);
            end
        end
        out_ready = 1'b1;
        step();
        n_tests++;
        if ({out_valid, pix_addr} !== {1'b1, ADDR_W'(12)}) begin
            n_fail++;
            $display("FAIL stall_resume: got valid=%0b addr=%0d, want 1 12", out_valid, pix_addr);
        end
        run_to_done(beats, cycles, to);
        step();
        n_tests++;
        if (to || beats != 10 || frame_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL stall_finish: got timeout=%0b beats=%0d cnt=%0d, want 0 10 2", to, beats, frame_cnt);
        end
    endtask

    task automatic test_abort();
        int beats, cycles;
        bit to;
        start = 1'b1; op_sel = 2'd3; out_ready = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_tests++;
        if ({out_valid, aborted, busy, done} !== 4'b0100) begin
            n_fail++;
            $display("FAIL abort_pulse: got valid=%0b aborted=%0b busy=%0b done=%0b, want 0 1 0 0",
                     out_valid, aborted, busy, done);
        end
        step();
        n_tests++;
        if ({aborted, done, frame_cnt} !== {2'b00, 16'd2}) begin
            n_fail++;
            $display("FAIL abort_after: got aborted=%0b done=%0b cnt=%0d, want 0 0 2", aborted, done, frame_cnt);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        n_tests++;
        if ({out_valid, pix_addr, row, col, sof} !== {1'b1, ADDR_W'(0), ROW_W'(0), COL_W'(0), 1'b1}) begin
            n_fail++;
            $display("FAIL abort_restart: got valid=%0b addr=%0d row=%0d col=%0d sof=%0b, want 1 0 0 0 1",
                     out_valid, pix_addr, row, col, sof);
        end
        run_to_done(beats, cycles, to);
        step();
        n_tests++;
        if (to || beats != 16 || frame_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL abort_rerun: got timeout=%0b beats=%0d cnt=%0d, want 0 16 3", to, beats, frame_cnt);
        end
    endtask

    task automatic test_start_while_busy();
        int beats, cycles;
        bit to;
        start = 1'b1; op_sel = 2'd1; out_ready = 1'b1;
        step();
        start = 1'b0;
        repeat (2) step();
        start = 1'b1; op_sel = 2'd3;
        step();
        start = 1'b0;
        n_tests++;
        if ({op_cur, pix_addr} !== {2'd1, ADDR_W'(6)}) begin
            n_fail++;
            $display("FAIL busy_start: got op=%0d addr=%0d, want 1 6", op_cur, pix_addr);
        end
        run_to_done(beats, cycles, to);
        step();
        n_tests++;
        if (to || beats != 13 || op_cur !== 2'd1 || frame_cnt !== 16'd4) begin
            n_fail++;
            $display("FAIL busy_finish: got timeout=%0b beats=%0d op=%0d cnt=%0d, want 0 13 1 4",
                     to, beats, op_cur, frame_cnt);
        end
    endtask

    task automatic test_async_reset();
        int beats, cycles;
        bit to;
        start = 1'b1; op_sel = 2'd2; out_ready = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        n_tests++;
        if (pix_addr !== ADDR_W'(12)) begin
            n_fail++;
            $display("FAIL rst_setup: got addr=%0d, want 12", pix_addr);
        end
        #2 HRESETn = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, pix_addr, row, col, op_cur, busy, done, aborted, frame_cnt} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got valid=%0b addr=%0d row=%0d col=%0d op=%0d busy=%0b cnt=%0d, want all 0",
                     out_valid, pix_addr, row, col, op_cur, busy, frame_cnt);
        end
        step();
        HRESETn = 1'b1;
        step();
        n_tests++;
        if ({aborted, done, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_no_pulse: got aborted=%0b done=%0b busy=%0b, want 0 0 0", aborted, done, busy);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        run_to_done(beats, cycles, to);
        step();
        n_tests++;
        if (to || beats != 16 || frame_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL rst_rerun: got timeout=%0b beats=%0d cnt=%0d, want 0 16 1", to, beats, frame_cnt);
        end
    endtask

`ifdef HBLANK_EN
    task automatic test_hblank();
        int beats, cycles;
        bit to;
        start = 1'b1; op_sel = 2'd0; out_ready = 1'b1;
        step();
        start = 1'b0;
        run_to_done(beats, cycles, to);
        n_tests++;
        if (to || beats != 16 || (cycles + 1) != 23) begin
            n_fail++;
            $display("FAIL hblank_timing: got timeout=%0b beats=%0d start_to_done=%0d, want 0 16 23",
                     to, beats, cycles + 1);
        end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_abort();
        test_start_while_busy();
        test_async_reset();
`ifdef HBLANK_EN
        test_hblank();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
